// File: rtl/inv_cipher.sv
// rtl/inv_cipher.sv - AES-128 iterative inverse cipher, one round per clock
module inv_cipher (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1407:0] key,
  input  logic [127:0]  state,
  output logic [127:0]  out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } fsm_t;

  // Entry x lives at [2047-8*x -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  fsm_t          r_fsm;
  fsm_t          w_fsm_next;
  logic [1407:0] r_key;
  logic [127:0]  r_data;
  logic [3:0]    r_cnt;
  logic          w_load;
  logic          w_round;
  logic          w_final;
  logic [127:0]  w_rk;
  logic [127:0]  w_isr;
  logic [127:0]  w_isb;
  logic [127:0]  w_round_out;
  logic [127:0]  w_last_out;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by any constant below 0x10 as a sum of b, 2b, 4b, 8b.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = s[127 - 8*(r + 4*c) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      o[119 - 32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      o[111 - 32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      o[103 - 32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      IDLE:    if (start) w_fsm_next = RUN;
      RUN:     if (r_cnt == 4'd1) w_fsm_next = LAST;
      LAST:    w_fsm_next = IDLE;
      default: w_fsm_next = IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_round = 1'b0;
    w_final = 1'b0;
    case (r_fsm)
      IDLE:    w_load  = start;
      RUN:     w_round = 1'b1;
      LAST:    w_final = 1'b1;
      default: w_load  = 1'b0;
    endcase
  end

  // Round key for the current counter value, taken from the latched schedule.
  always_comb begin
    w_rk = '0;
    for (int i = 0; i <= 10; i++) begin
      if (r_cnt == 4'(i)) w_rk = r_key[1407 - 128*i -: 128];
    end
  end

  assign w_isr       = inv_shift_rows(r_data);
  assign w_isb       = inv_sub_bytes(w_isr);
  assign w_round_out = inv_mix_columns(w_isb ^ w_rk);
  assign w_last_out  = w_isb ^ r_key[1407 -: 128];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key  <= '0;
      r_data <= '0;
      r_cnt  <= '0;
      out    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= w_final;
      if (w_load) begin
        r_key  <= key;
        r_data <= state ^ key[127:0];
        r_cnt  <= 4'd9;
        busy   <= 1'b1;
      end
      if (w_round) begin
        r_data <= w_round_out;
        if (r_cnt > 4'd1) r_cnt <= r_cnt - 4'd1;
      end
      if (w_final) begin
        out  <= w_last_out;
        busy <= 1'b0;
      end
    end
  end

endmodule
